// File: rtl/dehaze_pkg.sv
// Shared constants, types and helpers for the defog pipeline stages.
package dehaze_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned FRAC_DEF  = 4;
    localparam int unsigned T_MIN_DEF = 26;

    // Timing/control bits that travel alongside each pixel.
    typedef struct packed {
        logic bypass;
        logic en;
        logic hsync;
        logic vsync;
    } ctl_t;

    function automatic int unsigned calc_qw(input int unsigned dw, input int unsigned frac);
        return dw + frac;
    endfunction

    function automatic int unsigned calc_lat(input int unsigned dw, input int unsigned frac);
        return dw + frac + 2;
    endfunction

    // Clamp a signed value into [0, 2^dw-1].
    function automatic logic [31:0] sat_u(input logic signed [31:0] v, input int unsigned dw);
        logic [31:0] maxv;
        maxv = (32'd1 << dw) - 32'd1;
        if (v < 0) begin
            return '0;
        end else if (v > $signed(maxv)) begin
            return maxv;
        end
        return v;
    endfunction

endpackage

// File: rtl/dehaze_recover_recip_pipe.sv
// Pipelined restoring divider: recip = floor((2^DW-1)*2^FRAC / max(t, T_MIN)), QW cycles.
module recip_pipe
    import dehaze_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned T_MIN = T_MIN_DEF
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [DW-1:0]        t,
    output logic [DW+FRAC-1:0]   recip
);

    localparam int unsigned QW = calc_qw(DW, FRAC);
    localparam logic [QW-1:0] NUM = {QW{1'b1}} << FRAC;

    logic [DW-1:0] t_eff;
    logic [DW-1:0] rem_q [QW];
    logic [DW-1:0] div_q [QW];
    logic [QW-1:0] quo_q [QW];

    assign t_eff = (t < DW'(T_MIN)) ? DW'(T_MIN) : t;

    for (genvar i = 0; i < QW; i++) begin : g_stage
        logic [DW-1:0] rem_in;
        logic [DW-1:0] div_in;
        logic [QW-1:0] quo_in;
        logic [DW:0]   trial;
        logic [DW-1:0] rem_d;
        logic [QW-1:0] quo_d;

        if (i == 0) begin : g_first
            assign rem_in = '0;
            assign div_in = t_eff;
            assign quo_in = '0;
        end else begin : g_next
            assign rem_in = rem_q[i-1];
            assign div_in = div_q[i-1];
            assign quo_in = quo_q[i-1];
        end

        // Stage i resolves quotient bit QW-1-i; remainder stays below the divisor.
        always_comb begin
            trial = {rem_in, NUM[QW-1-i]};
            rem_d = trial[DW-1:0];
            quo_d = quo_in;
            if (trial >= {1'b0, div_in}) begin
                rem_d          = DW'(trial - {1'b0, div_in});
                quo_d[QW-1-i]  = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                rem_q[i] <= '0;
                div_q[i] <= '0;
                quo_q[i] <= '0;
            end else begin
                rem_q[i] <= rem_d;
                div_q[i] <= div_in;
                quo_q[i] <= quo_d;
            end
        end
    end

    assign recip = quo_q[QW-1];

endmodule

// File: rtl/dehaze_recover.sv
// Scene-radiance recovery J = A - (A - I)/t per channel, with frame-latched A,
// saturation, bypass and blanking. Fixed latency DW+FRAC+2, one pixel per clock.
module dehaze_recover
    import dehaze_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CH    = 3,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned T_MIN = T_MIN_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             en,
    input  logic [CH*DW-1:0] pix,
    input  logic [DW-1:0]    t,
    input  logic [CH*DW-1:0] a_light,
    input  logic             bypass,
    output logic [CH*DW-1:0] o_pix,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_en
);

    localparam int unsigned QW = calc_qw(DW, FRAC);
    localparam int unsigned PW = DW + QW + 1;
    localparam int unsigned JW = PW + 1;

    ctl_t             ctl_in;
    ctl_t             ctl_dq [QW];
    logic [CH*DW-1:0] pix_dq [QW];
    logic [QW-1:0]    recip;

    ctl_t             ctl_a;
    logic [CH*DW-1:0] pix_a;
    logic             a_load;
    logic [CH*DW-1:0] a_q;
    logic [CH*DW-1:0] a_use;

    ctl_t             ctl_s1;
    logic [CH*DW-1:0] pix_s1;
    logic [CH*DW-1:0] a_s1;
    logic [CH*DW-1:0] j_all;

    assign ctl_in = '{bypass: bypass, en: en, hsync: hsync, vsync: vsync};

    recip_pipe #(
        .DW    (DW),
        .FRAC  (FRAC),
        .T_MIN (T_MIN)
    ) u_recip (
        .clk   (clk),
        .nrst  (nrst),
        .t     (t),
        .recip (recip)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < QW; i++) begin
                ctl_dq[i] <= '0;
                pix_dq[i] <= '0;
            end
        end else begin
            ctl_dq[0] <= ctl_in;
            pix_dq[0] <= pix;
            for (int i = 1; i < QW; i++) begin
                ctl_dq[i] <= ctl_dq[i-1];
                pix_dq[i] <= pix_dq[i-1];
            end
        end
    end

    assign ctl_a = ctl_dq[QW-1];
    assign pix_a = pix_dq[QW-1];

    // ctl_s1 holds the previous aligned sample, so this is the delayed-vsync rise.
    // The pixel on that same edge already sees the freshly sampled A.
    assign a_load = ctl_a.vsync & ~ctl_s1.vsync;
    assign a_use  = a_load ? a_light : a_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_q    <= '1;
            ctl_s1 <= '0;
            pix_s1 <= '0;
            a_s1   <= '0;
        end else begin
            if (a_load) begin
                a_q <= a_light;
            end
            ctl_s1 <= ctl_a;
            pix_s1 <= pix_a;
            a_s1   <= a_use;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic signed [DW:0]   diff;
        logic signed [PW-1:0] prod_d;
        logic signed [PW-1:0] prod_q;
        logic signed [PW-1:0] corr;
        logic signed [JW-1:0] j_full;

        assign diff   = $signed({1'b0, a_use[k*DW +: DW]}) - $signed({1'b0, pix_a[k*DW +: DW]});
        assign prod_d = PW'(diff) * PW'($signed({1'b0, recip}));

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                prod_q <= '0;
            end else begin
                prod_q <= prod_d;
            end
        end

        assign corr   = prod_q >>> FRAC;
        assign j_full = JW'($signed({1'b0, a_s1[k*DW +: DW]})) - JW'(corr);
        assign j_all[k*DW +: DW] = DW'(sat_u(32'(j_full), DW));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_pix   <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_en    <= 1'b0;
        end else begin
            if (!ctl_s1.en) begin
                o_pix <= '0;
            end else if (ctl_s1.bypass) begin
                o_pix <= pix_s1;
            end else begin
                o_pix <= j_all;
            end
            o_hsync <= ctl_s1.hsync;
            o_vsync <= ctl_s1.vsync;
            o_en    <= ctl_s1.en;
        end
    end

endmodule

// File: tb/tb_dehaze_recover.sv
// Directed, table-driven bench for dehaze_recover at default parameters.
module tb_dehaze_recover;

    localparam int L = 14;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        en = 1'b0;
    logic        bypass = 1'b0;
    logic [23:0] pix = '0;
    logic [23:0] a_light = '0;
    logic [7:0]  t = '0;
    logic [23:0] o_pix;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_en;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  t;
        logic [23:0] a;
        logic [23:0] i;
        logic [23:0] j;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    dehaze_recover #(
        .DW    (8),
        .CH    (3),
        .FRAC  (4),
        .T_MIN (26)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .hsync   (hsync),
        .vsync   (vsync),
        .en      (en),
        .pix     (pix),
        .t       (t),
        .a_light (a_light),
        .bypass  (bypass),
        .o_pix   (o_pix),
        .o_hsync (o_hsync),
        .o_vsync (o_vsync),
        .o_en    (o_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        hsync = 1'b0;
        vsync = 1'b0;
        en    = 1'b0;
        pix   = '0;
        t     = '0;
    endtask

    // One input cycle, then sample the outputs exactly L cycles later.
    task automatic send(input logic vs, input logic e, input logic [7:0] tt,
                        input logic [23:0] ii, output logic [23:0] got, output logic got_en);
        vsync = vs;
        en    = e;
        t     = tt;
        pix   = ii;
        step();
        idle();
        steps(L - 1);
        got    = o_pix;
        got_en = o_en;
    endtask

    function automatic logic [23:0] rep3(input logic [7:0] v);
        return {v, v, v};
    endfunction

    logic [23:0] got;
    logic        got_en;

    initial begin
        vecs[0] = '{t: 8'd255, a: rep3(8'd200), i: rep3(8'd100), j: rep3(8'd100)};
        vecs[1] = '{t: 8'd128, a: rep3(8'd200), i: rep3(8'd100), j: rep3(8'd7)};
        vecs[2] = '{t: 8'd64,  a: rep3(8'd200), i: rep3(8'd50),  j: rep3(8'd0)};
        vecs[3] = '{t: 8'd128, a: rep3(8'd100), i: rep3(8'd200), j: rep3(8'd255)};
        vecs[4] = '{t: 8'd0,   a: rep3(8'd200), i: rep3(8'd190), j: rep3(8'd103)};
        vecs[5] = '{t: 8'd10,  a: rep3(8'd200), i: rep3(8'd190), j: rep3(8'd103)};
        vecs[6] = '{t: 8'd26,  a: rep3(8'd200), i: rep3(8'd190), j: rep3(8'd103)};
        vecs[7] = '{t: 8'd27,  a: rep3(8'd200), i: rep3(8'd190), j: rep3(8'd106)};
        vecs[8] = '{t: 8'd255, a: 24'h0AC85A,   i: 24'h323C46,   j: 24'h323C46};

        #1 nrst = 1'b0;
        steps(3);
        check("reset o_pix", 32'(o_pix), 32'h0);
        check("reset o_en", 32'(o_en), 32'h0);
        check("reset o_vsync", 32'(o_vsync), 32'h0);
        nrst = 1'b1;
        step();

        // Vsync pulse, then one pixel with hsync; timing and data both land L later.
        foreach (vecs[n]) begin
            a_light = vecs[n].a;
            idle();
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            en    = 1'b1;
            hsync = 1'b1;
            pix   = vecs[n].i;
            t     = vecs[n].t;
            step();
            idle();
            steps(L - 2);
            check($sformatf("vec%0d o_vsync@L", n), 32'(o_vsync), 32'h1);
            check($sformatf("vec%0d o_en@L-1", n), 32'(o_en), 32'h0);
            check($sformatf("vec%0d o_hsync@L-1", n), 32'(o_hsync), 32'h0);
            step();
            check($sformatf("vec%0d o_pix", n), 32'(o_pix), 32'(vecs[n].j));
            check($sformatf("vec%0d o_en", n), 32'(o_en), 32'h1);
            check($sformatf("vec%0d o_hsync", n), 32'(o_hsync), 32'h1);
            check($sformatf("vec%0d o_vsync after", n), 32'(o_vsync), 32'h0);
        end

        // Frame latch: a_light changes without vsync are ignored.
        a_light = rep3(8'd200);
        send(1'b1, 1'b0, 8'd0, 24'h0, got, got_en);
        a_light = rep3(8'd50);
        send(1'b0, 1'b1, 8'd128, rep3(8'd100), got, got_en);
        check("latch old A", 32'(got), 32'(rep3(8'd7)));
        send(1'b1, 1'b0, 8'd0, 24'h0, got, got_en);
        send(1'b0, 1'b1, 8'd128, rep3(8'd100), got, got_en);
        check("latch new A", 32'(got), 32'(rep3(8'd147)));
        // Pixel arriving on the vsync edge itself already uses the new A.
        a_light = rep3(8'd200);
        send(1'b1, 1'b1, 8'd128, rep3(8'd100), got, got_en);
        check("same-edge A", 32'(got), 32'(rep3(8'd7)));

        // Bypass and blanking.
        bypass = 1'b1;
        send(1'b0, 1'b1, 8'd64, 24'h123456, got, got_en);
        check("bypass o_pix", 32'(got), 32'h123456);
        send(1'b0, 1'b0, 8'd64, 24'h123456, got, got_en);
        check("bypass blank o_pix", 32'(got), 32'h0);
        bypass = 1'b0;
        send(1'b0, 1'b0, 8'd255, 24'hAABBCC, got, got_en);
        check("blank o_pix", 32'(got), 32'h0);
        check("blank o_en", 32'(got_en), 32'h0);

        // Reset mid-line with a full pipeline.
        en    = 1'b1;
        hsync = 1'b1;
        t     = 8'd255;
        pix   = rep3(8'd100);
        steps(L + 2);
        check("stream o_en", 32'(o_en), 32'h1);
        check("stream o_pix", 32'(o_pix), 32'(rep3(8'd100)));
        #2 nrst = 1'b0;
        #1;
        check("async rst o_pix", 32'(o_pix), 32'h0);
        check("async rst o_en", 32'(o_en), 32'h0);
        check("async rst o_hsync", 32'(o_hsync), 32'h0);
        a_light = '0;
        t       = 8'd128;
        pix     = rep3(8'd200);
        step();
        nrst = 1'b1;
        for (int c = 1; c < L; c++) begin
            step();
            check($sformatf("post-rst o_en c%0d", c), 32'(o_en), 32'h0);
        end
        step();
        check("post-rst o_en", 32'(o_en), 32'h1);
        check("post-rst A=255", 32'(o_pix), 32'(rep3(8'd149)));
        idle();
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dehaze_recover.md
# dehaze_recover

Parametrised scene-radiance recovery stage for the defog pipeline. It computes J = A − (A − I)/t per channel, where A is the atmospheric light and t the transmission. Compared with the fixed 8-bit RGB stage, it adds configurable width and channel count, a per-channel A latched once per frame, a t floor, signed difference handling with saturation, bypass and blanking. It sits after the transmission/dark-channel estimators and drives the display/output formatter.

## Interface
- DW, 8: pixel and transmission width
- CH, 3: channel count
- FRAC, 4: fractional bits of reciprocal 1/t
- T_MIN, 26: transmission floor, in units of 1/(2^DW−1); legal range 1..2^DW−1
- clk  in  1  pixel clock
- nrst  in  1  reset, asynchronous, active-low
- hsync, vsync, en  in  1 each  input timing and data-valid
- pix  in  CH*DW  input pixel I; channel k at [k*DW +: DW]
- t  in  DW  transmission for this pixel, scaled by 2^DW−1
- a_light  in  CH*DW  atmospheric light A per channel
- bypass  in  1  quasi-static; 1 = pass pix through unchanged
- o_pix  out  CH*DW  recovered pixel J
- o_hsync, o_vsync, o_en  out  1 each  timing delayed to match o_pix

## Operation
- QW = DW+FRAC. L = QW+2.
- t_eff = max(t, T_MIN).
- recip = floor((2^DW−1)·2^FRAC / t_eff), QW bits unsigned. It is produced by a pipelined restoring divider with one quotient bit per stage, i.e. QW stages.
- pix, en, hsync, vsync and bypass are delayed QW cycles to align with recip.
- A register (CH*DW): loads a_light on the rising edge of vsync delayed QW cycles. Every pixel of a frame therefore uses one A value.
- Stage QW+1, per channel:
  - diff = A − I, signed DW+1 bits.
  - prod = diff · recip, signed DW+QW+1 bits, registered.
- Stage QW+2, per channel:
  - corr = prod >>> FRAC (arithmetic shift, floor toward −∞).
  - J = A − corr, evaluated in sufficient signed width.
  - J is saturated to [0, 2^DW−1] and registered.
- bypass = 1: o_pix is pix delayed L cycles; latency is identical and the arithmetic result is discarded.
- o_en = 0: o_pix forced to 0 (blanking); timing outputs are unaffected.

## Timing
- Latency is L cycles for all outputs: 14 at defaults. Throughput is one pixel per clock, with no stalls and no handshake.
- Reset (any time, including mid-frame):
  - all pipeline registers, o_pix, o_hsync, o_vsync and o_en go to 0;
  - the A register goes to all-ones;
  - the first L cycles after release output 0/low.
- A update and a pixel at the same delayed-vsync edge: that pixel already uses the new A.
- Changes to a_light between delayed-vsync edges have no effect.
- t = 0 and t < T_MIN are both treated as T_MIN. t = 2^DW−1 gives recip = 2^FRAC, so J = I exactly.
- bypass must only change during vertical blanking. A mid-frame toggle takes effect per pixel after L cycles, with no glitch beyond that pixel.

## Structure
- Shared package dehaze_pkg holds:
  - the defaults for DW, FRAC and T_MIN;
  - a constant function for QW and L;
  - a saturate-to-unsigned function, reused by other defog stages.
- One sub-module, recip_pipe: parameters DW, FRAC, T_MIN; inputs clk, nrst, t; output recip after QW cycles. It contains the clamp plus the restoring-division stages.
- The top level holds the delay lines, the A register, the CH multiply lanes (generate loop) and the saturation.

## Test plan
All scenarios use defaults DW=8, FRAC=4, CH=3, T_MIN=26.
- t=255, A=200, I=100 on all channels -> recip=16; J=100 after exactly 14 cycles, with o_en/o_hsync/o_vsync also delayed 14.
- t=128, A=200, I=100 -> recip=31, prod=3100, corr=193; J=7.
- Low-side saturation: t=64, A=200, I=50 -> recip=63, corr=590; J=0.
- High-side saturation: t=128, A=100, I=200 -> prod=−3100, corr=−194; J=255.
- t floor: t=0 and t=10, A=200, I=190 -> t_eff=26, recip=156, corr=97; J=103 for both.
- Frame latch, bypass, blanking and reset:
  - change a_light mid-frame -> o_pix keeps the old A until the next delayed vsync rise;
  - bypass=1 -> o_pix equals pix, delayed 14;
  - en=0 -> o_pix=0;
  - nrst pulse mid-line -> all outputs 0 immediately, A=255, then valid output resumes 14 cycles after new input.
